// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: PS/2 scan codes, the 2-bit game command encoding
// and the PS/2 receiver frame states.
package tetris_pkg;

  typedef logic [1:0] cmd_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam cmd_t CMD_UP    = 2'b00;
  localparam cmd_t CMD_LEFT  = 2'b01;
  localparam cmd_t CMD_RIGHT = 2'b10;
  localparam cmd_t CMD_ENTER = 2'b11;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  typedef struct packed {
    logic hit;
    cmd_t cmd;
  } key_map_t;

  // Arrows only count with the E0 prefix; Enter only without it.
  function automatic key_map_t decode_code(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '{hit: 1'b0, cmd: CMD_UP};
    if (ext) begin
      case (code)
        SC_UP:    m = '{hit: 1'b1, cmd: CMD_UP};
        SC_LEFT:  m = '{hit: 1'b1, cmd: CMD_LEFT};
        SC_RIGHT: m = '{hit: 1'b1, cmd: CMD_RIGHT};
        default:  m = '{hit: 1'b0, cmd: CMD_UP};
      endcase
    end else if (code == SC_ENTER) begin
      m = '{hit: 1'b1, cmd: CMD_ENTER};
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Command-side bundle between the key decoder and the game controller.
interface ps2_key_decoder_if;
  import tetris_pkg::*;

  cmd_t keyboard_signal;
  logic key_valid;
  logic frame_error;

  modport master (output keyboard_signal, output key_valid, output frame_error);
  modport slave  (input keyboard_signal, input key_valid, input frame_error);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop checks and a saturating inactivity timeout.
module ps2_rx
  import tetris_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TMax = CntW'(TIMEOUT_CYCLES - 1);

  logic            clk_s1, clk_s2, clk_s3;
  logic            data_s1, data_s2;
  logic            fall;
  rx_state_e       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity;
  logic [CntW-1:0] to_cnt;

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizers reset to the PS/2 idle level so reset itself makes no edge.
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_s3      <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      state       <= StIdle;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      to_cnt      <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_error <= 1'b0;
    end else begin
      clk_s1      <= ps2_clk;
      clk_s2      <= clk_s1;
      clk_s3      <= clk_s2;
      data_s1     <= ps2_data;
      data_s2     <= data_s1;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          StIdle: begin
            if (!data_s2) begin
              state   <= StData;
              bit_cnt <= '0;
            end
          end
          StData: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= StParity;
          end
          StParity: begin
            parity <= data_s2;
            state  <= StStop;
          end
          StStop: begin
            if (data_s2 && (^{parity, shift})) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_error <= 1'b1;
            end
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end else if (state != StIdle) begin
        if (to_cnt == TMax) begin
          state       <= StIdle;
          frame_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 make/break sequences for Up/Left/Right/Enter into one-cycle game
// command strobes, with per-key typematic repeat filtering.
module ps2_key_decoder
  import tetris_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [3:0]  REPEAT_MASK    = 4'b0110
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_decoder_if.master  kbd
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_error;
  logic       ext_q, brk_q;
  logic [3:0] held_q;
  logic       key_valid_q;
  cmd_t       cmd_q;
  key_map_t   map;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(rx_frame_error)
  );

  assign map = decode_code(ext_q, byte_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      key_valid_q <= 1'b0;
      cmd_q       <= CMD_UP;
    end else begin
      key_valid_q <= 1'b0;
      if (rx_frame_error) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (byte_data == SC_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (map.hit) begin
            if (brk_q) begin
              held_q[map.cmd] <= 1'b0;
            end else begin
              // A still-held key only re-fires if its repeat bit is set.
              if (!held_q[map.cmd] || REPEAT_MASK[map.cmd]) begin
                key_valid_q <= 1'b1;
                cmd_q       <= map.cmd;
              end
              held_q[map.cmd] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign kbd.key_valid       = key_valid_q;
  assign kbd.keyboard_signal = cmd_q;
  assign kbd.frame_error     = rx_frame_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, strobe counting
// monitor, and cycle-exact latency checks on the key and timeout paths.
module tb_ps2_key_decoder;
  import tetris_pkg::*;

  localparam int unsigned TO = 60;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;

  ps2_key_decoder_if kbd_if ();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TO),
    .REPEAT_MASK   (4'b0110)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kbd     (kbd_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int kv_cnt  = 0;
  int fe_cnt  = 0;
  logic [1:0] last_cmd = 2'b00;

  always @(negedge clk) begin
    if (kbd_if.key_valid) begin
      kv_cnt++;
      last_cmd = kbd_if.keyboard_signal;
    end
    if (kbd_if.frame_error) fe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_fall(input logic b);
    ps2_data = b;
    tick(4);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_fall(b);
    tick(8);
    ps2_clk = 1'b1;
    tick(4);
  endtask

  // Everything up to (not including) the stop bit.
  task automatic send_head(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_head(b, bad_par);
    ps2_bit(1'b1);
    tick(10);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kv0, fe0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(3);
    check_eq("reset_kv", kbd_if.key_valid, 0);
    check_eq("reset_fe", kbd_if.frame_error, 0);
    check_eq("reset_sig", kbd_if.keyboard_signal, 0);
    rst = 1'b0;
    tick(5);

    // Right arrow make with cycle-exact latency from the stop-bit fall.
    kv0 = kv_cnt;
    send_byte(SC_EXT, 1'b0);
    check_eq("e0_alone_no_kv", kv_cnt - kv0, 0);
    send_head(SC_RIGHT, 1'b0);
    ps2_fall(1'b1);
    tick(3);
    check_eq("right_kv_early", kbd_if.key_valid, 0);
    tick(1);
    check_eq("right_kv_at4", kbd_if.key_valid, 1);
    check_eq("right_sig_at4", kbd_if.keyboard_signal, 2);
    tick(1);
    check_eq("right_kv_one_cycle", kbd_if.key_valid, 0);
    tick(4);
    ps2_clk = 1'b1;
    tick(10);
    check_eq("right_kv_count", kv_cnt - kv0, 1);

    // Enter held (no repeat), released, pressed again.
    kv0 = kv_cnt;
    for (int i = 0; i < 3; i++) send_byte(SC_ENTER, 1'b0);
    send_byte(SC_BRK, 1'b0);
    send_byte(SC_ENTER, 1'b0);
    check_eq("enter_held_kv", kv_cnt - kv0, 1);
    check_eq("enter_cmd", last_cmd, 3);
    send_byte(SC_ENTER, 1'b0);
    check_eq("enter_again_kv", kv_cnt - kv0, 2);

    // Left typematic repeat is allowed; its break produces nothing.
    kv0 = kv_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(SC_EXT, 1'b0);
      send_byte(SC_LEFT, 1'b0);
    end
    check_eq("left_repeat_kv", kv_cnt - kv0, 3);
    check_eq("left_cmd", last_cmd, 1);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_BRK, 1'b0);
    send_byte(SC_LEFT, 1'b0);
    check_eq("left_break_kv", kv_cnt - kv0, 3);

    // Parity fault: one error cycle, no key; decoding recovers.
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_byte(SC_UP, 1'b1);
    check_eq("parity_fe_cycles", fe_cnt - fe0, 1);
    check_eq("parity_no_kv", kv_cnt - kv0, 0);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_UP, 1'b0);
    check_eq("up_after_err_kv", kv_cnt - kv0, 1);
    check_eq("up_after_err_cmd", last_cmd, 0);

    // Timeout after start + 4 data bits.
    kv0 = kv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    ps2_fall(1'b0);
    tick(8);
    ps2_clk = 1'b1;
    tick(int'(TO) + 2 - 8);
    check_eq("timeout_fe_early", kbd_if.frame_error, 0);
    tick(1);
    check_eq("timeout_fe_at_limit", kbd_if.frame_error, 1);
    tick(1);
    check_eq("timeout_fe_one_cycle", kbd_if.frame_error, 0);
    check_eq("timeout_fe_count", fe_cnt - fe0, 1);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    check_eq("after_timeout_kv", kv_cnt - kv0, 1);
    check_eq("after_timeout_cmd", last_cmd, 2);

    // Reset mid-frame, then an unknown extended key.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    tick(2);
    check_eq("midrst_kv", kbd_if.key_valid, 0);
    check_eq("midrst_fe", kbd_if.frame_error, 0);
    check_eq("midrst_sig", kbd_if.keyboard_signal, 0);
    rst = 1'b0;
    tick(5);
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_byte(SC_EXT, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_eq("unknown_no_kv", kv_cnt - kv0, 0);
    send_byte(SC_RIGHT, 1'b0);
    check_eq("bare_74_no_kv", kv_cnt - kv0, 0);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    check_eq("right_after_rst_kv", kv_cnt - kv0, 1);
    check_eq("right_after_rst_cmd", last_cmd, 2);
    check_eq("no_errors_after_rst", fe_cnt - fe0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
